digit_scan_convert: RTL and testbench

Parametrised scan-and-convert engine over an internal DEPTH x DATA_W register file. On go, it walks every entry and counts the entries whose value lies in a programmable inclusive range [lo, hi], for example ASCII '0'..'9' = 48..57. In convert mode it also rewrites each matching entry in place as value - offset. A host port loads and reads back the array while the engine is idle; results are reported through count and done.

---
 rtl/digit_scan_convert_pkg.sv | 24 ++
 rtl/digit_scan_convert_if.sv | 30 +++
 rtl/digit_scan_convert_scan_regfile.sv | 30 +++
 rtl/digit_scan_convert.sv | 146 ++++++++++++++
 tb/tb_digit_scan_convert.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/digit_scan_convert_pkg.sv
// Shared definitions for the digit scan/convert engine: default geometry,
// FSM state encoding and the ASCII digit range.
package digit_scan_convert_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = 4;

  localparam logic [7:0] ASCII_ZERO = 8'd48;
  localparam logic [7:0] ASCII_NINE = 8'd57;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CHECK = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic is_ascii_digit(input logic [7:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/digit_scan_convert_if.sv
// Control, status and host access signals of digit_scan_convert.
interface digit_scan_convert_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();

  logic              go;
  logic              mode;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] offset;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;

  modport master (
    output go, mode, lo, hi, offset, host_we, host_addr, host_wdata,
    input  host_rdata, busy, done, count
  );

  modport slave (
    input  go, mode, lo, hi, offset, host_we, host_addr, host_wdata,
    output host_rdata, busy, done, count
  );

endinterface

// File: rtl/digit_scan_convert_scan_regfile.sv
// DEPTH x DATA_W register file with one synchronous read port, one write
// port, and a synchronous clear of every entry on Rst.
module scan_regfile #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // A read that coincides with a write to the same address returns old data.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/digit_scan_convert.sv
// Scan engine: counts entries in [lo, hi] and optionally rewrites them as
// value - offset. Define NONMATCH_ZERO_EN to zero non-matching entries in convert mode.
module digit_scan_convert
  import digit_scan_convert_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic               Clk,
  input logic               Rst,
  digit_scan_convert_if.slave bus
);

  state_t            state_q, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   count_q;
  logic              mode_q;
  logic [DATA_W-1:0] lo_q, hi_q, off_q, wr_val_q;
  logic              start, inc_idx, busy, last, match, need_write;
  logic [DATA_W-1:0] rf_rdata, rf_wdata;
  logic [ADDR_W-1:0] rf_raddr, rf_waddr;
  logic              rf_we;
  logic              host_sel;
  logic [DATA_W-1:0] host_hold;

  assign busy  = (state_q == READ) || (state_q == CHECK) || (state_q == WRITE);
  assign last  = (idx == ADDR_W'(DEPTH - 1));
  assign match = (rf_rdata >= lo_q) && (rf_rdata <= hi_q);

`ifdef NONMATCH_ZERO_EN
  assign need_write = mode_q;
`else
  assign need_write = mode_q && match;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    start     = 1'b0;
    inc_idx   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.go) begin
          start     = 1'b1;
          state_nxt = READ;
        end
      end
      READ: state_nxt = CHECK;
      CHECK: begin
        if (need_write) begin
          state_nxt = WRITE;
        end else if (last) begin
          state_nxt = DONE;
        end else begin
          inc_idx   = 1'b1;
          state_nxt = READ;
        end
      end
      WRITE: begin
        if (last) begin
          state_nxt = DONE;
        end else begin
          inc_idx   = 1'b1;
          state_nxt = READ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Scan parameters are frozen at go so the host may change them mid-scan.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx      <= '0;
      count_q  <= '0;
      mode_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      off_q    <= '0;
      wr_val_q <= '0;
    end else if (start) begin
      idx     <= '0;
      count_q <= '0;
      mode_q  <= bus.mode;
      lo_q    <= bus.lo;
      hi_q    <= bus.hi;
      off_q   <= bus.offset;
    end else begin
      if (state_q == CHECK) begin
        if (match) count_q <= count_q + (ADDR_W + 1)'(1);
        wr_val_q <= match ? (rf_rdata - off_q) : '0;
      end
      if (inc_idx) idx <= idx + ADDR_W'(1);
    end
  end

  // The engine owns both array ports while busy; otherwise the host does.
  always_comb begin
    rf_raddr = bus.host_addr;
    rf_waddr = bus.host_addr;
    rf_wdata = bus.host_wdata;
    rf_we    = bus.host_we;
    if (busy) begin
      rf_raddr = idx;
      rf_waddr = idx;
      rf_wdata = wr_val_q;
      rf_we    = (state_q == WRITE);
    end
  end

  scan_regfile #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_regfile (
    .Clk  (Clk),
    .Rst  (Rst),
    .raddr(rf_raddr),
    .rdata(rf_rdata),
    .we   (rf_we),
    .waddr(rf_waddr),
    .wdata(rf_wdata)
  );

  // host_rdata follows the array only for cycles answering a host read.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      host_sel  <= 1'b0;
      host_hold <= '0;
    end else begin
      host_sel <= !busy && !bus.host_we;
      if (host_sel) host_hold <= rf_rdata;
    end
  end

  assign bus.host_rdata = host_sel ? rf_rdata : host_hold;
  assign bus.busy       = busy;
  assign bus.done       = (state_q == DONE);
  assign bus.count      = count_q;

endmodule

// File: tb/tb_digit_scan_convert.sv
// Directed, table-driven bench for digit_scan_convert (DEPTH=16, DATA_W=8);
// expectations follow NONMATCH_ZERO_EN when it is defined.
module tb_digit_scan_convert;
  import digit_scan_convert_pkg::*;

  logic Clk;
  logic Rst;

  digit_scan_convert_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  digit_scan_convert #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [127:0] init;
    logic         mode;
    logic [7:0]   lo;
    logic [7:0]   hi;
    logic [7:0]   off;
    logic [7:0]   exp_count;
    logic [7:0]   exp_lat;
    logic [127:0] exp_arr;
  } vec_t;

  localparam logic [127:0] INIT_MIX = 128'h41316232433364344535663647376838;
  localparam logic [127:0] CONV_MIX = 128'h41016202430364044505660647076808;
  localparam logic [127:0] ZERO_MIX = 128'h00010002000300040005000600070008;
  localparam logic [127:0] ALL_57   = {16{8'h39}};
  localparam logic [127:0] ALL_9    = {16{8'h09}};

  int   total;
  int   bad;
  vec_t vecs [4];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] entry_of(input logic [127:0] v, input int k);
    return v[(15 - k) * 8 +: 8];
  endfunction

  task automatic writeEntry(input int addr, input logic [7:0] data);
    bus.host_addr  = 4'(addr);
    bus.host_wdata = data;
    bus.host_we    = 1'b1;
    tick();
    bus.host_we    = 1'b0;
  endtask

  task automatic readEntry(input int addr, output logic [7:0] data);
    bus.host_addr = 4'(addr);
    bus.host_we   = 1'b0;
    tick();
    data = bus.host_rdata;
  endtask

  // Starts a scan, scrambles the inputs after go, and measures edges to done.
  task automatic runScan(input logic mode, input logic [7:0] lo, input logic [7:0] hi,
                         input logic [7:0] off, output int lat);
    bus.mode   = mode;
    bus.lo     = lo;
    bus.hi     = hi;
    bus.offset = off;
    bus.go     = 1'b1;
    tick();
    bus.go      = 1'b0;
    bus.host_we = 1'b0;
    bus.mode    = ~mode;
    bus.lo      = 8'h00;
    bus.hi      = 8'hFF;
    bus.offset  = 8'h11;
    checkOutput("done_clear_on_go", int'(bus.done), 0);
    checkOutput("busy_on_go", int'(bus.busy), 1);
    lat = 0;
    while (!bus.done && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    int         lat;
    logic [7:0] d;
    for (int k = 0; k < 16; k++) writeEntry(k, entry_of(v.init, k));
    runScan(v.mode, v.lo, v.hi, v.off, lat);
    checkOutput($sformatf("v%0d_latency", n), lat, int'(v.exp_lat));
    checkOutput($sformatf("v%0d_count", n), int'(bus.count), int'(v.exp_count));
    checkOutput($sformatf("v%0d_busy_low", n), int'(bus.busy), 0);
    for (int k = 0; k < 16; k++) begin
      readEntry(k, d);
      checkOutput($sformatf("v%0d_entry%0d", n, k), int'(d), int'(entry_of(v.exp_arr, k)));
    end
  endtask

  initial begin
    int         lat;
    logic [7:0] d;
    total = 0;
    bad   = 0;

    vecs[0] = '{INIT_MIX, 1'b0, ASCII_ZERO, ASCII_NINE, 8'd48, 8'd8, 8'd32, INIT_MIX};
`ifdef NONMATCH_ZERO_EN
    vecs[1] = '{INIT_MIX, 1'b1, ASCII_ZERO, ASCII_NINE, 8'd48, 8'd8, 8'd48, ZERO_MIX};
`else
    vecs[1] = '{INIT_MIX, 1'b1, ASCII_ZERO, ASCII_NINE, 8'd48, 8'd8, 8'd40, CONV_MIX};
`endif
    vecs[2] = '{ALL_57, 1'b1, ASCII_ZERO, ASCII_NINE, 8'd48, 8'd16, 8'd48, ALL_9};
`ifdef NONMATCH_ZERO_EN
    vecs[3] = '{INIT_MIX, 1'b1, 8'd60, 8'd50, 8'd48, 8'd0, 8'd48, 128'h0};
`else
    vecs[3] = '{INIT_MIX, 1'b1, 8'd60, 8'd50, 8'd48, 8'd0, 8'd32, INIT_MIX};
`endif

    bus.go = 1'b0; bus.mode = 1'b0; bus.lo = '0; bus.hi = '0; bus.offset = '0;
    bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    Rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_count", int'(bus.count), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_rdata", int'(bus.host_rdata), 0);
    Rst = 1'b0;

    for (int n = 0; n < 4; n++) applyStimulus(vecs[n], n);

    $display("[TB] restart from DONE");
    checkOutput("done_before_restart", int'(bus.done), 1);
    runScan(1'b0, 8'h00, 8'hFF, 8'h00, lat);
    checkOutput("restart_latency", lat, 32);
    checkOutput("restart_count", int'(bus.count), 16);

    $display("[TB] reset in the middle of a convert scan");
    for (int k = 0; k < 16; k++) writeEntry(k, 8'h39);
    bus.mode = 1'b1; bus.lo = ASCII_ZERO; bus.hi = ASCII_NINE; bus.offset = 8'd48;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    repeat (10) tick();
    checkOutput("midscan_busy", int'(bus.busy), 1);
    checkOutput("midscan_count_nonzero", int'(bus.count != 0), 1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checkOutput("midrst_count", int'(bus.count), 0);
    checkOutput("midrst_done", int'(bus.done), 0);
    checkOutput("midrst_busy", int'(bus.busy), 0);
    checkOutput("midrst_rdata", int'(bus.host_rdata), 0);
    for (int k = 0; k < 16; k++) begin
      readEntry(k, d);
      checkOutput($sformatf("midrst_entry%0d", k), int'(d), 0);
    end

    $display("[TB] host write together with go");
    bus.host_we = 1'b1; bus.host_addr = 4'd3; bus.host_wdata = 8'h37;
    runScan(1'b0, ASCII_ZERO, ASCII_NINE, 8'd0, lat);
    checkOutput("wrgo_latency", lat, 32);
    checkOutput("wrgo_count", int'(bus.count), 1);

    $display("[TB] host write dropped while busy");
    readEntry(3, d);
    checkOutput("pre_busy_read", int'(d), 8'h37);
    bus.mode = 1'b0; bus.lo = ASCII_ZERO; bus.hi = ASCII_NINE; bus.offset = 8'd0;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    repeat (3) tick();
    bus.host_addr = 4'd7;
    tick();
    checkOutput("rdata_hold_busy", int'(bus.host_rdata), 8'h37);
    bus.host_we = 1'b1; bus.host_addr = 4'd3; bus.host_wdata = 8'hAA;
    tick();
    bus.host_we = 1'b0;
    lat = 0;
    while (!bus.done && lat < 200) begin
      tick();
      lat++;
    end
    checkOutput("busywr_done_reached", int'(bus.done), 1);
    checkOutput("busywr_count", int'(bus.count), 1);
    readEntry(3, d);
    checkOutput("busywr_entry3", int'(d), 8'h37);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
